// File: rtl/hidden_cpu_sequencer.sv
// Program buffer and run controller for the HiddenCPU core: captures instructions in LOAD,
// replays them by core PC in RUN. Optional macro SEQ_SINGLE_STEP_EN adds the step_req gate.
module hidden_cpu_sequencer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int MAX_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              run_en,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  input  logic [7:0]        core_pc,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_req,
`endif
  output logic [5:0]        instr_out,
  output logic              instr_valid,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              overflow,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_V  = DEPTH[ADDR_W:0];
  localparam logic [7:0]      WDOG_MAX = MAX_CYCLES[7:0];

  logic [5:0]        mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;
  logic [7:0]        wdog_q, wdog_d;
  logic [5:0]        instr_out_q, instr_out_d;
  logic              instr_valid_q, instr_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              overflow_q, overflow_d;
  logic              mem_we_s;
  logic              eval_s;
  logic [7:0]        prog_len_ext_s;
  logic [ADDR_W-1:0] rd_idx_s;
  logic              unused_byte_bits_s;

  assign unused_byte_bits_s = ^in_byte[1:0];
  assign prog_len_ext_s     = 8'(prog_len_q);
  assign rd_idx_s           = core_pc[ADDR_W-1:0];

`ifdef SEQ_SINGLE_STEP_EN
  assign eval_s = step_req;
`else
  assign eval_s = 1'b1;
`endif

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    prog_len_d    = prog_len_q;
    wdog_d        = wdog_q;
    instr_out_d   = instr_out_q;
    instr_valid_d = 1'b0;
    done_d        = done_q;
    timeout_d     = timeout_q;
    overflow_d    = overflow_q;
    mem_we_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          state_d    = S_LOAD;
          wr_ptr_d   = '0;
          prog_len_d = '0;
          overflow_d = 1'b0;
        end else if (run_en && (prog_len_q != '0)) begin
          state_d   = S_RUN;
          wdog_d    = 8'd0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (wr_ptr_q != DEPTH_V) begin
            mem_we_s   = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            prog_len_d = wr_ptr_q + 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end else begin
          overflow_d = overflow_q;
        end
        if (!load_en) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        if (!run_en) begin
          state_d = S_IDLE;
        end else if (!eval_s) begin
          state_d = S_RUN;
        end else if (core_pc >= prog_len_ext_s) begin
          // a branch past the end halts; the PC is never folded into the buffer
          state_d = S_HALT;
          done_d  = 1'b1;
        end else if (wdog_q == WDOG_MAX) begin
          state_d   = S_HALT;
          timeout_d = 1'b1;
        end else begin
          instr_out_d   = mem_q[rd_idx_s];
          instr_valid_d = 1'b1;
          wdog_d        = wdog_q + 8'd1;
        end
      end
      S_HALT: begin
        if (!run_en) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      wdog_q        <= 8'd0;
      instr_out_q   <= 6'd0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      prog_len_q    <= prog_len_d;
      wdog_q        <= wdog_d;
      instr_out_q   <= instr_out_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
      overflow_q    <= overflow_d;
    end
  end

  // Instruction buffer; left uncleared by reset since prog_len hides stale entries
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_byte[7:2];
    end
  end

  assign instr_out   = instr_out_q;
  assign instr_valid = instr_valid_q;
  assign prog_len    = prog_len_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign overflow    = overflow_q;
  assign state       = state_q;

endmodule

// File: tb/tb_hidden_cpu_sequencer.sv
// Directed bench for hidden_cpu_sequencer: a per-cycle vector table for load/run/halt,
// then hand sequences for overflow, watchdog, priority, reset abort and single-step.
module tb_hidden_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst, load_en, run_en, in_valid, step_req;
  logic [7:0] in_byte, core_pc;
  logic [5:0] instr_out;
  logic       instr_valid, busy, done, timeout, overflow;
  logic [4:0] prog_len;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hidden_cpu_sequencer #(.DEPTH(16), .ADDR_W(4), .MAX_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .run_en(run_en),
    .in_valid(in_valid), .in_byte(in_byte), .core_pc(core_pc),
`ifdef SEQ_SINGLE_STEP_EN
    .step_req(step_req),
`endif
    .instr_out(instr_out), .instr_valid(instr_valid), .prog_len(prog_len),
    .busy(busy), .done(done), .timeout(timeout), .overflow(overflow), .state(state)
  );

  typedef struct {
    logic       rst, load_en, run_en, in_valid;
    logic [7:0] in_byte, core_pc;
    logic [1:0] st;
    logic [5:0] iout;
    logic       iv;
    logic [4:0] plen;
    logic       bsy, dn, tmo, ovf;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(logic r, logic le, logic re, logic iv_in, logic [7:0] b,
                              logic [7:0] pc, logic [1:0] st, logic [5:0] io, logic iv,
                              logic [4:0] pl, logic bs, logic dn, logic tm, logic ov);
    vec_t v;
    v.rst = r; v.load_en = le; v.run_en = re; v.in_valid = iv_in; v.in_byte = b;
    v.core_pc = pc; v.st = st; v.iout = io; v.iv = iv; v.plen = pl;
    v.bsy = bs; v.dn = dn; v.tmo = tm; v.ovf = ov;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; load_en = 1'b0; run_en = 1'b0; in_valid = 1'b0;
    in_byte = 8'h00; core_pc = 8'h00; step_req = 1'b1;
  endtask

  task automatic load_byte(input logic [7:0] b);
    in_valid = 1'b1; in_byte = b;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int nv;
    idle_inputs();
    //            rst  le   re   iv   byte   pc     st     iout   ivo  plen   bsy  dn   tm   ov
    tbl[0]  = mk(1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,2'd0,6'h00,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0);
    tbl[1]  = mk(1'b1,1'b0,1'b0,1'b0,8'h00,8'h00,2'd0,6'h00,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0);
    tbl[2]  = mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,2'd0,6'h00,1'b0,5'd0,1'b0,1'b0,1'b0,1'b0);
    tbl[3]  = mk(1'b0,1'b1,1'b0,1'b0,8'h00,8'h00,2'd1,6'h00,1'b0,5'd0,1'b1,1'b0,1'b0,1'b0);
    tbl[4]  = mk(1'b0,1'b1,1'b0,1'b1,8'h04,8'h00,2'd1,6'h00,1'b0,5'd1,1'b1,1'b0,1'b0,1'b0);
    tbl[5]  = mk(1'b0,1'b1,1'b0,1'b1,8'h18,8'h00,2'd1,6'h00,1'b0,5'd2,1'b1,1'b0,1'b0,1'b0);
    tbl[6]  = mk(1'b0,1'b0,1'b0,1'b1,8'hFC,8'h00,2'd0,6'h00,1'b0,5'd3,1'b0,1'b0,1'b0,1'b0);
    tbl[7]  = mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,2'd2,6'h00,1'b0,5'd3,1'b1,1'b0,1'b0,1'b0);
    tbl[8]  = mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,2'd2,6'h01,1'b1,5'd3,1'b1,1'b0,1'b0,1'b0);
    tbl[9]  = mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h01,2'd2,6'h06,1'b1,5'd3,1'b1,1'b0,1'b0,1'b0);
    tbl[10] = mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h02,2'd2,6'h3F,1'b1,5'd3,1'b1,1'b0,1'b0,1'b0);
    tbl[11] = mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h03,2'd3,6'h3F,1'b0,5'd3,1'b0,1'b1,1'b0,1'b0);
    tbl[12] = mk(1'b0,1'b0,1'b1,1'b0,8'h00,8'h00,2'd3,6'h3F,1'b0,5'd3,1'b0,1'b1,1'b0,1'b0);
    tbl[13] = mk(1'b0,1'b0,1'b0,1'b0,8'h00,8'h00,2'd0,6'h3F,1'b0,5'd3,1'b0,1'b1,1'b0,1'b0);

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst; load_en = tbl[i].load_en; run_en = tbl[i].run_en;
      in_valid = tbl[i].in_valid; in_byte = tbl[i].in_byte; core_pc = tbl[i].core_pc;
      step();
      chk($sformatf("v%0d.state", i),    8'(state),       8'(tbl[i].st));
      chk($sformatf("v%0d.instr", i),    8'(instr_out),   8'(tbl[i].iout));
      chk($sformatf("v%0d.ivalid", i),   8'(instr_valid), 8'(tbl[i].iv));
      chk($sformatf("v%0d.prog_len", i), 8'(prog_len),    8'(tbl[i].plen));
      chk($sformatf("v%0d.busy", i),     8'(busy),        8'(tbl[i].bsy));
      chk($sformatf("v%0d.done", i),     8'(done),        8'(tbl[i].dn));
      chk($sformatf("v%0d.timeout", i),  8'(timeout),     8'(tbl[i].tmo));
      chk($sformatf("v%0d.overflow", i), 8'(overflow),    8'(tbl[i].ovf));
    end
    idle_inputs();

    // Overflow: 17 writes into a 16-entry buffer; byte i carries instruction 3*i+1
    load_en = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      load_byte({6'(i * 3 + 1), 2'b11});
      if (i == 15) begin
        chk("ovf.len_at_full", 8'(prog_len), 8'd16);
        chk("ovf.flag_at_full", 8'(overflow), 8'd0);
      end
    end
    chk("ovf.len_after", 8'(prog_len), 8'd16);
    chk("ovf.flag_after", 8'(overflow), 8'd1);
    load_en = 1'b0;
    step();
    run_en = 1'b1;
    step();
    chk("ovf.run_entry_done_clr", 8'(done), 8'd0);
    core_pc = 8'd15;
    step();
    chk("ovf.mem15", 8'(instr_out), 8'h2E);
    chk("ovf.mem15_valid", 8'(instr_valid), 8'd1);
    core_pc = 8'd16;
    step();
    chk("ovf.pc16_state", 8'(state), 8'd3);
    chk("ovf.pc16_done", 8'(done), 8'd1);
    idle_inputs();
    step();

    // Watchdog: 4-instruction program, PC held at 0, limit 5
    load_en = 1'b1;
    step();
    load_byte(8'h08); load_byte(8'h0C); load_byte(8'h10); load_byte(8'h14);
    load_en = 1'b0;
    step();
    chk("wdog.prog_len", 8'(prog_len), 8'd4);
    run_en = 1'b1;
    core_pc = 8'd0;
    step();
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (instr_valid) nv++;
      if (state == 2'd3) break;
    end
    chk("wdog.issue_count", 8'(nv), 8'd5);
    chk("wdog.state", 8'(state), 8'd3);
    chk("wdog.timeout", 8'(timeout), 8'd1);
    chk("wdog.done", 8'(done), 8'd0);
    chk("wdog.instr_hold", 8'(instr_out), 8'h02);
    run_en = 1'b0;
    step();
    chk("wdog.exit_idle", 8'(state), 8'd0);

    // Priority: load_en wins over run_en; then a run aborted by reset
    load_en = 1'b1; run_en = 1'b1;
    step();
    chk("prio.state", 8'(state), 8'd1);
    chk("prio.len_clr", 8'(prog_len), 8'd0);
    load_en = 1'b0;
    load_byte(8'hA8);
    chk("prio.last_write_len", 8'(prog_len), 8'd1);
    chk("prio.back_idle", 8'(state), 8'd0);
    step();
    chk("prio.run_state", 8'(state), 8'd2);
    chk("prio.timeout_clr", 8'(timeout), 8'd0);
    core_pc = 8'd0;
    step();
    chk("prio.instr", 8'(instr_out), 8'h2A);
    rst = 1'b1;
    step();
    chk("rst.state", 8'(state), 8'd0);
    chk("rst.prog_len", 8'(prog_len), 8'd0);
    chk("rst.ivalid", 8'(instr_valid), 8'd0);
    chk("rst.instr", 8'(instr_out), 8'd0);
    chk("rst.busy", 8'(busy), 8'd0);
    idle_inputs();
    step();

`ifdef SEQ_SINGLE_STEP_EN
    // Single-step: 2 step pulses in 6 RUN cycles
    load_en = 1'b1;
    step();
    load_byte(8'h04); load_byte(8'h18);
    load_en = 1'b0;
    step();
    run_en = 1'b1;
    step();
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      step_req = (c == 1 || c == 4) ? 1'b1 : 1'b0;
      step();
      if (instr_valid) nv++;
    end
    step_req = 1'b0;
    step();
    if (instr_valid) nv++;
    chk("step.pulses", 8'(nv), 8'd2);
    chk("step.wdog", dut.wdog_q, 8'd2);
    chk("step.state", 8'(state), 8'd2);
    idle_inputs();
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hidden_cpu_sequencer.md
Name: hidden_cpu_sequencer

Overview:
Program buffer and run controller for the 2-bit-opcode HiddenCPU core. The block captures 6-bit instructions (opcode + two register addresses) from the pin bus into a small on-chip buffer. It then replays them to the core, indexed by the core's PC, so PC-relative branches work. It sits between the 8-bit input pins and the core's instruction inputs, and also provides end-of-program and watchdog halting.

Parameters:
DEPTH, 16, number of instruction slots (power of two, 4..64)
ADDR_W, 4, log2(DEPTH)
MAX_CYCLES, 255, RUN-cycle watchdog limit (1..255)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
load_en  input  1  level; request/hold LOAD mode
run_en  input  1  level; request/hold RUN mode
in_valid  input  1  in_byte carries an instruction this cycle (LOAD only)
in_byte  input  8  instruction byte; [7:2] = {reg1Addr, reg0Addr, opcode}, [1:0] ignored
core_pc  input  8  core program counter
instr_out  output  6  instruction to core, registered
instr_valid  output  1  instr_out valid this cycle
prog_len  output  ADDR_W+1  number of stored instructions
busy  output  1  state is LOAD or RUN
done  output  1  sticky; program ran off its end
timeout  output  1  sticky; watchdog expired
overflow  output  1  sticky; write attempted while buffer full
state  output  2  IDLE=0, LOAD=1, RUN=2, HALT=3

Behaviour:
- Reset: state=IDLE; prog_len=0, wr_ptr=0, wdog=0; instr_out=0, instr_valid=0, done=0, timeout=0, overflow=0. Buffer contents are not cleared; they are unreachable because prog_len=0. Reset mid-LOAD or mid-RUN aborts immediately.
- IDLE:
  - load_en=1 -> LOAD; wr_ptr<=0, prog_len<=0, overflow<=0.
  - Else, run_en=1 and prog_len!=0 -> RUN; wdog<=0, done<=0, timeout<=0.
  - run_en with prog_len=0 stays IDLE.
  - load_en has priority when both are high.
- LOAD:
  - A cycle with in_valid=1 and wr_ptr<DEPTH writes mem[wr_ptr]<=in_byte[7:2]; wr_ptr++; prog_len<=wr_ptr+1.
  - in_valid=1 with wr_ptr==DEPTH: no write, overflow<=1.
  - load_en=0 -> IDLE; a write in the same cycle still occurs.
  - instr_valid=0 throughout.
- RUN, evaluated each cycle with idx=core_pc[ADDR_W-1:0]:
  - If core_pc>=prog_len (full 8-bit compare) -> HALT, done<=1, instr_valid<=0.
  - Else if wdog==MAX_CYCLES -> HALT, timeout<=1, instr_valid<=0.
  - Else instr_out<=mem[idx], instr_valid<=1, wdog++.
  - Latency: one cycle from core_pc to instr_out.
  - run_en=0 -> IDLE; instr_valid<=0, flags unchanged. End-of-program has priority over the watchdog in the same cycle.
- HALT:
  - instr_valid=0, instr_out holds its last value.
  - Leaves to IDLE only when run_en=0.
  - done and timeout hold until the next RUN entry or rst.
- PC wrap: core_pc is 8-bit and compared unsigned against prog_len, so a branch past the program end halts. No modulo indexing.
- busy=(state==LOAD)|(state==RUN). All outputs are registered.

Optional Feature:
SEQ_SINGLE_STEP_EN
- Defined:
  - Adds input step_req (1 bit). In RUN, the issue, end-of-program and watchdog checks only occur on cycles with step_req=1.
  - On other cycles instr_valid=0 and wdog holds.
  - step_req held high for N cycles issues N instructions.
- Undefined: the port is absent and RUN evaluates every cycle as described above.

Test Plan:
- Reset, then load 3 bytes 0x04,0x18,0xFC with in_valid, drop load_en -> prog_len=3, state=IDLE, overflow=0.
- After that load, run_en=1, core_pc driven 0,1,2 on consecutive cycles -> instr_out 0x01,0x06,0x3F each one cycle later with instr_valid=1. core_pc=3 -> state=HALT, done=1, instr_valid=0.
- Load 17 valid bytes with DEPTH=16 -> prog_len=16, overflow=1, mem[15] equals the 16th byte.
- MAX_CYCLES=5, prog_len=4, core_pc held at 0 -> exactly 5 valid issues, then HALT with timeout=1, done=0.
- load_en and run_en both asserted in IDLE -> LOAD entered. rst asserted in RUN -> next cycle IDLE, prog_len=0, instr_valid=0.
- SEQ_SINGLE_STEP_EN defined, RUN with step_req pulsed on 2 of 6 cycles -> exactly 2 instr_valid pulses, wdog=2.
